// File: rtl/t5_wbarb_if.sv
// Bus bundle between the t5 fetch/data requesters, the arbiter and the external Wishbone slave.
// master: the arbiter's view; slave: the view of the surrounding requesters and bus slave.
interface t5_wbarb_if;
   logic        iwb_stb;
   logic [31:2] iwb_adr;
   logic        iwb_ack;
   logic [31:0] iwb_dat;

   logic        dwb_stb;
   logic        dwb_we;
   logic [3:0]  dwb_sel;
   logic [31:2] dwb_adr;
   logic [31:0] dwb_dto;
   logic        dwb_ack;
   logic [31:0] dwb_dti;

   logic        xwb_cyc;
   logic        xwb_stb;
   logic        xwb_we;
   logic [3:0]  xwb_sel;
   logic [31:2] xwb_adr;
   logic [31:0] xwb_dto;
   logic        xwb_ack;
   logic [31:0] xwb_dti;

   modport master (
      input  iwb_stb, iwb_adr,
      input  dwb_stb, dwb_we, dwb_sel, dwb_adr, dwb_dto,
      input  xwb_ack, xwb_dti,
      output iwb_ack, iwb_dat,
      output dwb_ack, dwb_dti,
      output xwb_cyc, xwb_stb, xwb_we, xwb_sel, xwb_adr, xwb_dto
   );

   modport slave (
      output iwb_stb, iwb_adr,
      output dwb_stb, dwb_we, dwb_sel, dwb_adr, dwb_dto,
      output xwb_ack, xwb_dti,
      input  iwb_ack, iwb_dat,
      input  dwb_ack, dwb_dti,
      input  xwb_cyc, xwb_stb, xwb_we, xwb_sel, xwb_adr, xwb_dto
   );
endinterface

// File: rtl/t5_wbarb.sv
// Fetch/data arbiter onto the single classic-cycle Wishbone port; also produces pipeline enable sena.
// Optional bus timeout: define T5_WBARB_TIMEOUT_EN.
module t5_wbarb #(
   parameter int unsigned TOUT = 255,
   parameter int unsigned TOW  = 8
) (
   input  logic        sclk,
   input  logic        srst,
   t5_wbarb_if.master  bus,
   output logic        sena,
   output logic        berr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IBUS = 2'd1,
      ST_DBUS = 2'd2
   } state_t;

   localparam logic LG_DATA = 1'b1;

   if (TOUT >= (64'd1 << TOW)) begin : g_bad_tout
      $error("t5_wbarb: TOUT does not fit in TOW bits");
   end

   state_t      state_q, state_d;
   logic        lgnt_q, lgnt_d;
   logic        xcyc_q, xcyc_d;
   logic        xwe_q, xwe_d;
   logic [3:0]  xsel_q, xsel_d;
   logic [31:2] xadr_q, xadr_d;
   logic [31:0] xdto_q, xdto_d;
   logic        iack_q, iack_d;
   logic [31:0] idat_q, idat_d;
   logic        dack_q, dack_d;
   logic [31:0] ddat_q, ddat_d;

   logic        gnt_dat_c;
   logic        tout_hit_c;
   logic        resp_c;
   logic [31:0] resp_dat_c;

`ifdef T5_WBARB_TIMEOUT_EN
   logic [TOW-1:0] cnt_q, cnt_d;
   logic           berr_q, berr_d;

   assign tout_hit_c = (cnt_q == TOW'(TOUT));
   assign berr       = berr_q;
`else
   assign tout_hit_c = 1'b0;
   assign berr       = 1'b0;
`endif

   // Contended grant goes to whichever side was not granted last.
   assign gnt_dat_c  = bus.dwb_stb & (~bus.iwb_stb | (lgnt_q != LG_DATA));
   assign resp_c     = bus.xwb_ack | tout_hit_c;
   assign resp_dat_c = bus.xwb_ack ? bus.xwb_dti : 32'hDEAD_BEEF;

   assign sena = ~((bus.iwb_stb & ~iack_q) | (bus.dwb_stb & ~dack_q));

   assign bus.xwb_cyc = xcyc_q;
   assign bus.xwb_stb = xcyc_q;
   assign bus.xwb_we  = xwe_q;
   assign bus.xwb_sel = xsel_q;
   assign bus.xwb_adr = xadr_q;
   assign bus.xwb_dto = xdto_q;
   assign bus.iwb_ack = iack_q;
   assign bus.iwb_dat = idat_q;
   assign bus.dwb_ack = dack_q;
   assign bus.dwb_dti = ddat_q;

   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         state_q <= ST_IDLE;
         lgnt_q  <= LG_DATA;
         xcyc_q  <= 1'b0;
         xwe_q   <= 1'b0;
         xsel_q  <= 4'h0;
         xadr_q  <= 30'h0;
         xdto_q  <= 32'h0;
         iack_q  <= 1'b0;
         idat_q  <= 32'h0;
         dack_q  <= 1'b0;
         ddat_q  <= 32'h0;
`ifdef T5_WBARB_TIMEOUT_EN
         cnt_q   <= '0;
         berr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         lgnt_q  <= lgnt_d;
         xcyc_q  <= xcyc_d;
         xwe_q   <= xwe_d;
         xsel_q  <= xsel_d;
         xadr_q  <= xadr_d;
         xdto_q  <= xdto_d;
         iack_q  <= iack_d;
         idat_q  <= idat_d;
         dack_q  <= dack_d;
         ddat_q  <= ddat_d;
`ifdef T5_WBARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         berr_q  <= berr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      lgnt_d  = lgnt_q;
      xcyc_d  = xcyc_q;
      xwe_d   = xwe_q;
      xsel_d  = xsel_q;
      xadr_d  = xadr_q;
      xdto_d  = xdto_q;
      iack_d  = 1'b0;
      idat_d  = idat_q;
      dack_d  = 1'b0;
      ddat_d  = ddat_q;
`ifdef T5_WBARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      berr_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (gnt_dat_c) begin
               state_d = ST_DBUS;
               lgnt_d  = LG_DATA;
               xcyc_d  = 1'b1;
               xwe_d   = bus.dwb_we;
               xsel_d  = bus.dwb_sel;
               xadr_d  = bus.dwb_adr;
               xdto_d  = bus.dwb_dto;
`ifdef T5_WBARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else if (bus.iwb_stb) begin
               state_d = ST_IBUS;
               lgnt_d  = ~LG_DATA;
               xcyc_d  = 1'b1;
               xwe_d   = 1'b0;
               xsel_d  = 4'hF;
               xadr_d  = bus.iwb_adr;
               xdto_d  = 32'h0;
`ifdef T5_WBARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_IBUS, ST_DBUS: begin
            // Slave ack or timeout ends the cycle; ack wins when both coincide.
            if (resp_c) begin
               state_d = ST_IDLE;
               xcyc_d  = 1'b0;
               if (state_q == ST_DBUS) begin
                  dack_d = 1'b1;
                  ddat_d = resp_dat_c;
               end else begin
                  iack_d = 1'b1;
                  idat_d = resp_dat_c;
               end
`ifdef T5_WBARB_TIMEOUT_EN
               berr_d = ~bus.xwb_ack;
            end else begin
               cnt_d = cnt_q + TOW'(1);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_t5_wbarb.sv
// Directed scoreboard bench for t5_wbarb: arbitration order, wait states, stb drop, reset and timeout.
module tb_t5_wbarb;
`ifdef T5_WBARB_TIMEOUT_EN
   localparam int unsigned TB_TOUT = 4;
   localparam int          HANG    = 2;
`else
   localparam int unsigned TB_TOUT = 255;
   localparam int          HANG    = 20;
`endif

   logic sclk;
   logic srst;
   logic sena;
   logic berr;

   t5_wbarb_if bus();

   t5_wbarb #(.TOUT(TB_TOUT), .TOW(8)) dut (
      .sclk (sclk),
      .srst (srst),
      .bus  (bus),
      .sena (sena),
      .berr (berr)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   int total = 0;
   int bad   = 0;
   int nwait = 0;
   bit slave_hang = 1'b0;
   logic [66:0] exp_q[$];
   logic [66:0] obs_q[$];

   function automatic logic [31:0] data_for(input logic [29:0] a);
      return (a == 30'h40) ? 32'h0000_0013 : ({2'b00, a} ^ 32'hA5A5_0000);
   endfunction

   function automatic logic [66:0] tx(input logic [29:0] a, input logic we,
                                      input logic [3:0] sel, input logic [31:0] dto);
      return {a, we, sel, dto};
   endfunction

   task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_sb(input string tag);
      chk({tag, "_count"}, 67'(obs_q.size()), 67'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0)
         chk(tag, obs_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   // Slave model: acks after nwait strobe cycles, logs each completed transfer.
   initial begin
      int wcnt;
      wcnt = 0;
      bus.xwb_ack = 1'b0;
      bus.xwb_dti = 32'h0;
      forever begin
         @(negedge sclk);
         if (bus.xwb_stb === 1'b1 && !slave_hang) begin
            if (wcnt == nwait) begin
               bus.xwb_ack = 1'b1;
               bus.xwb_dti = data_for(bus.xwb_adr);
               obs_q.push_back(tx(bus.xwb_adr, bus.xwb_we, bus.xwb_sel, bus.xwb_dto));
               wcnt = 0;
            end else begin
               bus.xwb_ack = 1'b0;
               wcnt++;
            end
         end else begin
            bus.xwb_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      int  cyc;
      bit  got;
      bit  stable;
      bit  slo;

      srst = 1'b0;
      bus.iwb_stb = 1'b0; bus.iwb_adr = 30'h0;
      bus.dwb_stb = 1'b0; bus.dwb_we = 1'b0; bus.dwb_sel = 4'h0;
      bus.dwb_adr = 30'h0; bus.dwb_dto = 32'h0;
      tick(); tick();

      // Reset state
      chk("rst_xwb", 67'({bus.xwb_cyc, bus.xwb_stb, bus.xwb_we, bus.xwb_sel, bus.xwb_adr}), 67'(0));
      chk("rst_xdto", 67'(bus.xwb_dto), 67'(0));
      chk("rst_acks", 67'({bus.iwb_ack, bus.dwb_ack, berr}), 67'(0));
      chk("rst_data", 67'({bus.iwb_dat, bus.dwb_dti}), 67'(0));
      chk("rst_sena", 67'(sena), 67'(1));
      srst = 1'b1;
      tick();

      // Contended from reset: I, D, I
      bus.iwb_adr = 30'h80; bus.iwb_stb = 1'b1;
      bus.dwb_adr = 30'hC0; bus.dwb_we = 1'b1; bus.dwb_sel = 4'h3;
      bus.dwb_dto = 32'h0000_CAFE; bus.dwb_stb = 1'b1;
      exp_q.push_back(tx(30'h80, 1'b0, 4'hF, 32'h0));
      exp_q.push_back(tx(30'hC0, 1'b1, 4'h3, 32'h0000_CAFE));
      exp_q.push_back(tx(30'h80, 1'b0, 4'hF, 32'h0));
      #1 chk("arb_sena", 67'(sena), 67'(0));
      n = 0; cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.iwb_ack || bus.dwb_ack) n++;
         if (n == 3) begin
            cyc = i;
            break;
         end
      end
      chk("arb_cycles", 67'(cyc), 67'(6));
      chk("arb_last", 67'({bus.iwb_ack, bus.dwb_ack, bus.iwb_dat}), 67'({2'b10, data_for(30'h80)}));
      bus.iwb_stb = 1'b0; bus.dwb_stb = 1'b0;
      tick();
      check_sb("arb_sb");

      // Single fetch of 0x100
      bus.iwb_adr = 30'h40; bus.iwb_stb = 1'b1;
      exp_q.push_back(tx(30'h40, 1'b0, 4'hF, 32'h0));
      #1 chk("f_sena_req", 67'(sena), 67'(0));
      tick();
      chk("f_bus", 67'({bus.xwb_cyc, bus.xwb_stb, bus.xwb_we, bus.xwb_sel, bus.xwb_adr}),
          67'({3'b110, 4'hF, 30'h40}));
      chk("f_wait", 67'({sena, bus.iwb_ack}), 67'(0));
      tick();
      chk("f_ack", 67'({bus.iwb_ack, bus.xwb_stb, sena}), 67'(3'b101));
      chk("f_dat", 67'(bus.iwb_dat), 67'(32'h13));
      bus.iwb_stb = 1'b0;
      tick();
      chk("f_pulse", 67'({bus.iwb_ack, bus.iwb_dat}), 67'({1'b0, 32'h13}));
      check_sb("f_sb");

      // Five wait states on a data read
      nwait = 5;
      bus.dwb_adr = 30'h123; bus.dwb_we = 1'b0; bus.dwb_sel = 4'hF;
      bus.dwb_dto = 32'h1111; bus.dwb_stb = 1'b1;
      exp_q.push_back(tx(30'h123, 1'b0, 4'hF, 32'h1111));
      tick();
      n = 0; stable = 1'b1; slo = 1'b1;
      while (bus.xwb_stb === 1'b1 && n < 20) begin
         n++;
         if (bus.xwb_adr !== 30'h123) stable = 1'b0;
         if (sena !== 1'b0) slo = 1'b0;
         tick();
      end
      chk("ws_len", 67'(n), 67'(6));
      chk("ws_stable", 67'(stable), 67'(1));
      chk("ws_sena", 67'(slo), 67'(1));
      chk("ws_ack", 67'({bus.dwb_ack, bus.dwb_dti}), 67'({1'b1, data_for(30'h123)}));
      bus.dwb_stb = 1'b0;
      tick();
      chk("ws_pulse", 67'(bus.dwb_ack), 67'(0));
      check_sb("ws_sb");

      // Fetch drops stb after grant
      nwait = 2;
      bus.iwb_adr = 30'h55; bus.iwb_stb = 1'b1;
      exp_q.push_back(tx(30'h55, 1'b0, 4'hF, 32'h0));
      tick();
      bus.iwb_stb = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.iwb_ack) begin
            got = 1'b1;
            break;
         end
      end
      chk("drop_ack", 67'(got), 67'(1));
      tick();
      chk("drop_idle", 67'({bus.xwb_stb, bus.iwb_ack}), 67'(0));
      bus.dwb_adr = 30'h77; bus.dwb_we = 1'b0; bus.dwb_sel = 4'hF;
      bus.dwb_dto = 32'h0; bus.dwb_stb = 1'b1;
      exp_q.push_back(tx(30'h77, 1'b0, 4'hF, 32'h0));
      tick();
      chk("drop_regrant", 67'({bus.xwb_stb, bus.xwb_adr}), 67'({1'b1, 30'h77}));
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.dwb_ack) begin
            got = 1'b1;
            break;
         end
      end
      chk("drop_next_ack", 67'(got), 67'(1));
      bus.dwb_stb = 1'b0;
      nwait = 0;
      tick();
      check_sb("drop_sb");

`ifdef T5_WBARB_TIMEOUT_EN
      // Slave never acks: timeout fires
      slave_hang = 1'b1;
      bus.dwb_adr = 30'h99; bus.dwb_we = 1'b1; bus.dwb_sel = 4'hF;
      bus.dwb_dto = 32'h1234; bus.dwb_stb = 1'b1;
      tick();
      n = 0;
      while (bus.xwb_stb === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      chk("to_len", 67'(n), 67'(5));
      chk("to_pulse", 67'({bus.dwb_ack, berr}), 67'(2'b11));
      chk("to_dat", 67'(bus.dwb_dti), 67'(32'hDEAD_BEEF));
      bus.dwb_stb = 1'b0;
      tick();
      chk("to_end", 67'({bus.dwb_ack, berr, bus.xwb_stb}), 67'(0));
      slave_hang = 1'b0;
`endif

      // Hung fetch, then reset mid-transfer
      slave_hang = 1'b1;
      bus.iwb_adr = 30'h2A; bus.iwb_stb = 1'b1;
      tick();
      repeat (HANG) tick();
      chk("hang_stb", 67'({bus.xwb_stb, bus.iwb_ack}), 67'(2'b10));
      #2 srst = 1'b0;
      #1 chk("rst_async", 67'({bus.xwb_cyc, bus.xwb_stb, bus.iwb_ack}), 67'(0));
      tick(); tick();
      chk("rst_noack", 67'({bus.xwb_stb, bus.iwb_ack, berr}), 67'(0));
      slave_hang = 1'b0;
      bus.dwb_adr = 30'h3B; bus.dwb_we = 1'b0; bus.dwb_sel = 4'hF;
      bus.dwb_dto = 32'h0; bus.dwb_stb = 1'b1;
      exp_q.push_back(tx(30'h2A, 1'b0, 4'hF, 32'h0));
      exp_q.push_back(tx(30'h3B, 1'b0, 4'hF, 32'h0));
      srst = 1'b1;
      tick();
      chk("rst_lgnt", 67'({bus.xwb_stb, bus.xwb_we, bus.xwb_adr}), 67'({2'b10, 30'h2A}));
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.iwb_ack || bus.dwb_ack) n++;
         if (n == 2) break;
      end
      chk("rst_acks2", 67'(n), 67'(2));
      bus.iwb_stb = 1'b0; bus.dwb_stb = 1'b0;
      tick();
      check_sb("rst_sb");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
